// File: rtl/crc3_frame_tx.sv
// Serial frame transmitter: serializes DATA_W-bit words MSB-first, then appends a 3-bit CRC (x^3+x+1).
// Optional abort port pair is enabled by defining CRC3_FRAME_ABORT_EN.
module crc3_frame_tx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              tx_valid,
    output logic              tx_bit,
    output logic              tx_crc,
    output logic              busy,
    output logic              done,
    output logic [2:0]        crc_out
`ifdef CRC3_FRAME_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_FLUSH,
        ST_CRC
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               last_q;
    logic [2:0]         crc;
    logic [1:0]         phase;
    logic               take;
    logic               abort_hit;
    logic [2:0]         crc_data_nxt;
    logic [2:0]         crc_flush_nxt;

    function automatic logic [2:0] crc_step(input logic [2:0] c, input logic b);
        crc_step = {c[1:0], b} ^ (c[2] ? 3'b011 : 3'b000);
    endfunction

`ifdef CRC3_FRAME_ABORT_EN
    assign abort_hit = abort && (state != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign crc_data_nxt  = crc_step(crc, shreg[DATA_W-1]);
    assign crc_flush_nxt = crc_step(crc, 1'b0);

    // Ready is withheld during an abort so a word is never accepted and then dropped.
    always_comb begin
        s_ready = 1'b0;
        unique case (state)
            ST_IDLE: s_ready = 1'b1;
            ST_WAIT: s_ready = !abort_hit;
            ST_DATA: s_ready = (bit_cnt == '0) && !last_q && !abort_hit;
            default: s_ready = 1'b0;
        endcase
    end

    assign take = s_valid && s_ready;

    // Output registers are loaded with next-cycle values alongside the state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            last_q   <= 1'b0;
            crc      <= '0;
            crc_out  <= '0;
            phase    <= '0;
            tx_valid <= 1'b0;
            tx_bit   <= 1'b0;
            tx_crc   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef CRC3_FRAME_ABORT_EN
            aborted  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef CRC3_FRAME_ABORT_EN
            aborted <= 1'b0;
`endif
            if (abort_hit) begin
                state    <= ST_IDLE;
                tx_valid <= 1'b0;
                tx_bit   <= 1'b0;
                tx_crc   <= 1'b0;
                busy     <= 1'b0;
`ifdef CRC3_FRAME_ABORT_EN
                aborted  <= 1'b1;
`endif
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (take) begin
                            shreg    <= s_data;
                            last_q   <= s_last;
                            bit_cnt  <= CNT_W'(DATA_W - 1);
                            crc      <= '0;
                            state    <= ST_DATA;
                            busy     <= 1'b1;
                            tx_valid <= 1'b1;
                            tx_crc   <= 1'b0;
                            tx_bit   <= s_data[DATA_W-1];
                        end
                    end
                    ST_DATA: begin
                        crc <= crc_data_nxt;
                        if (bit_cnt != '0) begin
                            shreg   <= {shreg[DATA_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt - 1'b1;
                            tx_bit  <= shreg[DATA_W-2];
                        end else if (last_q) begin
                            state    <= ST_FLUSH;
                            phase    <= '0;
                            tx_valid <= 1'b0;
                            tx_bit   <= 1'b0;
                        end else if (take) begin
                            shreg   <= s_data;
                            last_q  <= s_last;
                            bit_cnt <= CNT_W'(DATA_W - 1);
                            tx_bit  <= s_data[DATA_W-1];
                        end else begin
                            state    <= ST_WAIT;
                            tx_valid <= 1'b0;
                            tx_bit   <= 1'b0;
                        end
                    end
                    ST_WAIT: begin
                        if (take) begin
                            shreg    <= s_data;
                            last_q   <= s_last;
                            bit_cnt  <= CNT_W'(DATA_W - 1);
                            state    <= ST_DATA;
                            tx_valid <= 1'b1;
                            tx_bit   <= s_data[DATA_W-1];
                        end
                    end
                    ST_FLUSH: begin
                        crc <= crc_flush_nxt;
                        if (phase == 2'd2) begin
                            crc_out  <= crc_flush_nxt;
                            state    <= ST_CRC;
                            phase    <= '0;
                            tx_valid <= 1'b1;
                            tx_crc   <= 1'b1;
                            tx_bit   <= crc_flush_nxt[2];
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    ST_CRC: begin
                        if (phase == 2'd2) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            tx_valid <= 1'b0;
                            tx_crc   <= 1'b0;
                            tx_bit   <= 1'b0;
                        end else begin
                            phase  <= phase + 1'b1;
                            tx_bit <= (phase == 2'd0) ? crc_out[1] : crc_out[0];
                            done   <= (phase == 2'd1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc3_frame_tx.sv
// Self-checking bench for crc3_frame_tx: directed and random frames against a polynomial-division model.
module tb_crc3_frame_tx;

    localparam int unsigned DW = 8;

    typedef logic [DW-1:0] word_q_t[$];
    typedef int unsigned   gap_q_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          tx_valid;
    logic          tx_bit;
    logic          tx_crc;
    logic          busy;
    logic          done;
    logic [2:0]    crc_out;
`ifdef CRC3_FRAME_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;
    logic [2:0]  model_crc_out;

    always #5 clk = ~clk;

    crc3_frame_tx #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .tx_valid (tx_valid),
        .tx_bit   (tx_bit),
        .tx_crc   (tx_crc),
        .busy     (busy),
        .done     (done),
        .crc_out  (crc_out)
`ifdef CRC3_FRAME_ABORT_EN
        ,
        .abort    (abort),
        .aborted  (aborted)
`endif
    );

    // Remainder of (message * x^3) mod (x^3 + x + 1) by long division over a bit list.
    function automatic logic [2:0] ref_crc(input word_q_t w);
        logic bits[$];
        int   n;
        foreach (w[k])
            for (int i = DW - 1; i >= 0; i--) bits.push_back(w[k][i]);
        repeat (3) bits.push_back(1'b0);
        n = bits.size();
        for (int i = 0; i + 3 < n; i++)
            if (bits[i]) begin
                bits[i]   = ~bits[i];
                bits[i+2] = ~bits[i+2];
                bits[i+3] = ~bits[i+3];
            end
        return {bits[n-3], bits[n-2], bits[n-1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [8:0] obs_vec();
        return {tx_valid, tx_bit, tx_crc, done, s_ready, busy, crc_out};
    endfunction

    // gaps[k] = cycles s_valid is held low before word k (k >= 1).
    task automatic run_frame(input string tag, input word_q_t words, input gap_q_t gaps);
        logic [8:0]  exp_q[$];
        int          drv_q[$];
        logic [2:0]  rem;
        logic [2:0]  prev;
        int          n;
        logic        rdy;
        int          d;
        n    = words.size();
        rem  = ref_crc(words);
        prev = model_crc_out;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < int'(DW); j++) begin
                rdy = (j == int'(DW) - 1) && (k < n - 1);
                d   = (rdy && gaps[k+1] == 0) ? k + 1 : -1;
                exp_q.push_back({1'b1, words[k][DW-1-j], 1'b0, 1'b0, rdy, 1'b1, prev});
                drv_q.push_back(d);
                if (rdy)
                    for (int g = 1; g <= int'(gaps[k+1]); g++) begin
                        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, prev});
                        drv_q.push_back(g == int'(gaps[k+1]) ? k + 1 : -1);
                    end
            end
        end
        repeat (3) begin
            exp_q.push_back({6'b000001, prev});
            drv_q.push_back(-1);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b1, rem[2-i], 1'b1, (i == 2), 1'b0, 1'b1, rem});
            drv_q.push_back(-1);
        end
        exp_q.push_back({6'b000010, rem});
        drv_q.push_back(-1);

        @(negedge clk);
        s_valid = 1'b1;
        s_data  = words[0];
        s_last  = (n == 1);
        #1 check({tag, "_accept_ready"}, 32'(s_ready), 32'd1);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            if (drv_q[c] >= 0) begin
                s_valid = 1'b1;
                s_data  = words[drv_q[c]];
                s_last  = (drv_q[c] == n - 1);
            end else if (exp_q[c][4] == 1'b0) begin
                s_valid = 1'($urandom);
                s_data  = DW'($urandom);
                s_last  = 1'($urandom);
            end else begin
                s_valid = 1'b0;
                s_data  = DW'($urandom);
                s_last  = 1'($urandom);
            end
            #1 check($sformatf("%s_cyc%0d", tag, c + 1), 32'(obs_vec()), 32'(exp_q[c]));
        end
        s_valid = 1'b0;
        model_crc_out = rem;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        word_q_t    wq;
        gap_q_t     gq;
        logic [2:0] crc_b2b;
        int         nw;

        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        s_last  = 1'b1;
`ifdef CRC3_FRAME_ABORT_EN
        abort   = 1'b0;
`endif
        model_crc_out = 3'b000;

        // Reset held two cycles with s_valid high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(obs_vec()), 32'({6'b000010, 3'b000}));
        rst     = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(obs_vec()), 32'({6'b000010, 3'b000}));

        wq = {}; gq = {};
        wq.push_back(8'hA5); gq.push_back(0);
        run_frame("a5", wq, gq);
        check("crc_out_a5", 32'(crc_out), 32'(3'b101));

        wq = {}; gq = {};
        wq.push_back(8'hFF); gq.push_back(0);
        run_frame("ff", wq, gq);
        check("crc_out_ff", 32'(crc_out), 32'(3'b011));

        wq = {}; gq = {};
        wq.push_back(8'h00); gq.push_back(0);
        run_frame("00", wq, gq);
        check("crc_out_00", 32'(crc_out), 32'(3'b000));

        wq = {}; gq = {};
        wq.push_back(8'hA5); wq.push_back(8'hFF);
        gq.push_back(0); gq.push_back(0);
        run_frame("b2b", wq, gq);
        crc_b2b = model_crc_out;

        // Force crc_out to a different value so the gapped frame must recompute it.
        wq = {}; gq = {};
        wq.push_back(8'hFF); gq.push_back(0);
        run_frame("ff2", wq, gq);

        wq = {}; gq = {};
        wq.push_back(8'hA5); wq.push_back(8'hFF);
        gq.push_back(0); gq.push_back(4);
        run_frame("gap4", wq, gq);
        check("gap_vs_b2b_crc", 32'(crc_out), 32'(crc_b2b));

        for (int f = 0; f < 12; f++) begin
            wq = {}; gq = {};
            nw = 1 + int'($urandom_range(3));
            for (int k = 0; k < nw; k++) begin
                wq.push_back(DW'($urandom));
                gq.push_back(k == 0 ? 0 : $urandom_range(3));
            end
            run_frame($sformatf("rnd%0d", f), wq, gq);
        end

        // Reset mid-frame: frame abandoned, no done pulse, crc_out cleared.
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h3C;
        s_last  = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_crc_out = 3'b000;
        for (int c = 0; c < 14; c++) begin
            check($sformatf("midrst_cyc%0d", c), 32'(obs_vec()), 32'({6'b000010, 3'b000}));
            @(negedge clk);
        end

`ifdef CRC3_FRAME_ABORT_EN
        wq = {}; gq = {};
        wq.push_back(8'h5A); gq.push_back(0);
        run_frame("pre_abort", wq, gq);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'hC3;
        s_last  = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1 check("abort_on_bit3_valid", 32'(tx_valid), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_pulse", 32'({aborted, obs_vec()}), 32'({1'b1, 6'b000010, model_crc_out}));
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            check($sformatf("post_abort_cyc%0d", c), 32'({aborted, obs_vec()}), 32'({1'b0, 6'b000010, model_crc_out}));
        end
        wq = {}; gq = {};
        wq.push_back(8'hA5); gq.push_back(0);
        run_frame("after_abort", wq, gq);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
